zap_shift_decode_stage: RTL and testbench

ZAP_SHIFT_DECODE_STAGE -- requirements
Module: zap_shift_decode_stage

---
 rtl/zap_shift_decode_stage.sv | 145 ++++++++++++++
 tb/tb_zap_shift_decode_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/zap_shift_decode_stage.sv
// Shifter operand decode stage: turns ARM shift fields into a normalised
// shift type/amount and buffers the result in a 2-entry skid FIFO.
module zap_shift_decode_stage #(
    parameter  int SHIFT_OPS = 7,
    localparam int TW        = $clog2(SHIFT_OPS)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_flush,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic [31:0]   i_source,
    input  logic [31:0]   i_rs_value,
    input  logic [4:0]    i_imm_amount,
    input  logic          i_amount_is_reg,
    input  logic [1:0]    i_shift_op,
    input  logic          i_carry,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [31:0]   o_source,
    output logic [7:0]    o_amount,
    output logic          o_carry,
    output logic [TW-1:0] o_shift_type
);

    localparam logic [TW-1:0] T_LSL   = TW'(0);
    localparam logic [TW-1:0] T_LSR   = TW'(1);
    localparam logic [TW-1:0] T_ASR   = TW'(2);
    localparam logic [TW-1:0] T_ROR_1 = TW'(5);
    localparam logic [TW-1:0] T_RRC   = TW'(6);

    localparam int EW = 32 + 8 + 1 + TW;

    logic [TW-1:0] dec_type;
    logic [7:0]    dec_amount;
    logic [EW-1:0] new_entry;

    logic [EW-1:0] entry_q [2];
    logic [EW-1:0] entry_d [2];
    logic [1:0]    count_q, count_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;

    logic          push;
    logic          pop;
    logic [EW-1:0] head;

    // Only the low byte of Rs is a shift amount.
    logic unused_rs_hi;
    assign unused_rs_hi = ^i_rs_value[31:8];

    always_comb begin
        dec_type   = T_LSL;
        dec_amount = 8'd0;
        if (i_amount_is_reg) begin
            dec_type   = TW'(i_shift_op);
            dec_amount = i_rs_value[7:0];
        end else begin
            case (i_shift_op)
                2'b00: begin
                    dec_type   = T_LSL;
                    dec_amount = {3'b000, i_imm_amount};
                end
                2'b01: begin
                    dec_type   = T_LSR;
                    dec_amount = (i_imm_amount == 5'd0) ? 8'd32 : {3'b000, i_imm_amount};
                end
                2'b10: begin
                    dec_type   = T_ASR;
                    dec_amount = (i_imm_amount == 5'd0) ? 8'd32 : {3'b000, i_imm_amount};
                end
                default: begin
                    // ROR #0 is the RRX encoding.
                    if (i_imm_amount == 5'd0) begin
                        dec_type   = T_RRC;
                        dec_amount = 8'd0;
                    end else begin
                        dec_type   = T_ROR_1;
                        dec_amount = {3'b000, i_imm_amount};
                    end
                end
            endcase
        end
    end

    assign new_entry = {i_source, dec_amount, i_carry, dec_type};

    assign o_ready = (count_q < 2'd2) && !i_flush;
    assign o_valid = (count_q != 2'd0);
    assign push    = i_valid && o_ready;
    assign pop     = o_valid && i_ready;
    assign head    = entry_q[rd_ptr_q];

    always_comb begin
        entry_d  = entry_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            entry_d[wr_ptr_q] = new_entry;
            wr_ptr_d          = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (i_flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload needs no reset: outputs are gated by o_valid.
    always_ff @(posedge i_clk) begin
        entry_q <= entry_d;
    end

    always_comb begin
        o_source     = 32'd0;
        o_amount     = 8'd0;
        o_carry      = 1'b0;
        o_shift_type = '0;
        if (o_valid) begin
            {o_source, o_amount, o_carry, o_shift_type} = head;
        end
    end

endmodule

// File: tb/tb_zap_shift_decode_stage.sv
// Randomised and directed bench for zap_shift_decode_stage against a
// queue-based reference model of the decode rules and 2-deep buffering.
module tb_zap_shift_decode_stage;

    localparam int TW = 3;

    logic          i_clk = 1'b0;
    logic          i_reset, i_flush, i_valid, i_ready;
    logic          o_ready, o_valid;
    logic [31:0]   i_source, i_rs_value;
    logic [4:0]    i_imm_amount;
    logic          i_amount_is_reg;
    logic [1:0]    i_shift_op;
    logic          i_carry;
    logic [31:0]   o_source;
    logic [7:0]    o_amount;
    logic          o_carry;
    logic [TW-1:0] o_shift_type;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] src;
        int          amt;
        logic        carry;
        int          typ;
    } ent_t;

    ent_t model_q[$];

    zap_shift_decode_stage #(.SHIFT_OPS(7)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_valid(i_valid),
        .o_ready(o_ready), .i_source(i_source), .i_rs_value(i_rs_value),
        .i_imm_amount(i_imm_amount), .i_amount_is_reg(i_amount_is_reg),
        .i_shift_op(i_shift_op), .i_carry(i_carry), .o_valid(o_valid),
        .i_ready(i_ready), .o_source(o_source), .o_amount(o_amount),
        .o_carry(o_carry), .o_shift_type(o_shift_type)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic ent_t ref_decode();
        ent_t e;
        int imm;
        imm     = int'(i_imm_amount);
        e.src   = i_source;
        e.carry = i_carry;
        if (i_amount_is_reg) begin
            e.typ = int'(i_shift_op);
            e.amt = int'(i_rs_value % 256);
        end else if (i_shift_op == 2'd0) begin
            e.typ = 0;
            e.amt = imm;
        end else if (i_shift_op == 2'd1 || i_shift_op == 2'd2) begin
            e.typ = int'(i_shift_op);
            e.amt = (imm == 0) ? 32 : imm;
        end else begin
            e.typ = (imm == 0) ? 6 : 5;
            e.amt = (imm == 0) ? 0 : imm;
        end
        return e;
    endfunction

    task automatic drv(input logic v, input logic [31:0] src, input logic [31:0] rs,
                       input logic [4:0] imm, input logic isreg, input logic [1:0] op,
                       input logic c);
        i_valid = v; i_source = src; i_rs_value = rs; i_imm_amount = imm;
        i_amount_is_reg = isreg; i_shift_op = op; i_carry = c;
    endtask

    task automatic drv_rand(input logic v);
        drv(v, $urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    endtask

    // Compare outputs on the falling edge, then advance the model on the rising edge.
    task automatic cycle();
        ent_t h;
        int   sz;
        logic do_pop, do_push;
        @(negedge i_clk);
        sz = model_q.size();
        if (sz > 0) begin
            h = model_q[0];
            check("o_valid", 64'(o_valid), 64'd1);
            check("o_source", 64'(o_source), 64'(h.src));
            check("o_amount", 64'(o_amount), 64'(h.amt));
            check("o_carry", 64'(o_carry), 64'(h.carry));
            check("o_shift_type", 64'(o_shift_type), 64'(h.typ));
        end else begin
            check("o_valid_idle", 64'(o_valid), 64'd0);
            check("o_data_idle", {o_source, o_amount, o_carry, o_shift_type}, 64'd0);
        end
        check("o_ready", 64'(o_ready), 64'((sz < 2) && !i_flush));
        @(posedge i_clk);
        if (i_reset) begin
            model_q.delete();
        end else begin
            do_pop  = (sz > 0) && i_ready;
            do_push = i_valid && (sz < 2) && !i_flush;
            if (do_pop) void'(model_q.pop_front());
            if (i_flush) model_q.delete();
            else if (do_push) model_q.push_back(ref_decode());
        end
        #1;
    endtask

    task automatic expect_head(input string tag, input int typ, input int amt, input logic [31:0] src);
        check({tag, "_type"}, 64'(o_shift_type), 64'(typ));
        check({tag, "_amt"}, 64'(o_amount), 64'(amt));
        check({tag, "_src"}, 64'(o_source), 64'(src));
    endtask

    initial begin
        i_reset = 1'b1; i_flush = 1'b0; i_ready = 1'b1;
        drv(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 2'd0, 1'b0);
        @(posedge i_clk);
        #1;
        model_q.delete();
        i_reset = 1'b0;
        cycle();

        // Decode corners with a streaming consumer.
        drv(1'b1, 32'h8000_0000, 32'd0, 5'd0, 1'b0, 2'b01, 1'b0);
        cycle();
        expect_head("lsr0", 1, 32, 32'h8000_0000);
        drv(1'b1, 32'h1234_5678, 32'd0, 5'd0, 1'b0, 2'b11, 1'b1);
        cycle();
        expect_head("rrx", 6, 0, 32'h1234_5678);
        drv(1'b1, 32'hCAFE_0001, 32'd0, 5'd4, 1'b0, 2'b11, 1'b0);
        cycle();
        expect_head("ror4", 5, 4, 32'hCAFE_0001);
        drv(1'b1, 32'h0000_00F0, 32'hFFFF_0121, 5'd9, 1'b1, 2'b10, 1'b1);
        cycle();
        expect_head("reg_asr", 2, 8'h21, 32'h0000_00F0);
        drv(1'b1, 32'h0000_0055, 32'd0, 5'd0, 1'b0, 2'b00, 1'b0);
        cycle();
        expect_head("lsl0", 0, 0, 32'h0000_0055);

        // Backpressure: three pushes with a stalled consumer, then drain.
        i_ready = 1'b0;
        drv(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 2'd0, 1'b0);
        cycle();
        i_ready = 1'b1;
        cycle();
        i_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 32'hA000_0000 + 32'(i), 32'd0, 5'(i + 1), 1'b0, 2'b00, 1'b0);
            cycle();
        end
        check("bp_ready_low", 64'(o_ready), 64'd0);
        expect_head("bp_head", 0, 1, 32'hA000_0000);
        i_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();

        // Streaming: ten back-to-back entries.
        for (int i = 0; i < 10; i++) begin
            drv_rand(1'b1);
            cycle();
        end
        drv(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 2'd0, 1'b0);
        cycle();

        // Flush with a full buffer and a valid input.
        i_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin drv_rand(1'b1); cycle(); end
        i_flush = 1'b1;
        drv_rand(1'b1);
        cycle();
        i_flush = 1'b0;
        drv(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 2'd0, 1'b0);
        cycle();
        check("flush_empty", 64'(o_valid), 64'd0);

        // Reset with a full buffer and a valid input.
        for (int i = 0; i < 2; i++) begin drv_rand(1'b1); cycle(); end
        i_reset = 1'b1;
        drv_rand(1'b1);
        cycle();
        i_reset = 1'b0;
        drv(1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 2'd0, 1'b0);
        check("reset_valid", 64'(o_valid), 64'd0);
        check("reset_ready", 64'(o_ready), 64'd1);
        cycle();

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            drv_rand(1'($urandom_range(0, 3) != 0));
            i_ready = 1'($urandom_range(0, 2) != 0);
            i_flush = ($urandom_range(0, 19) == 0);
            i_reset = ($urandom_range(0, 49) == 0);
            cycle();
        end
        i_flush = 1'b0; i_reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
